dot_product_ctrl: RTL

//   Sequencer for the dense vector-vector multiplier: walks two operand buffers, streams element pairs

---
 rtl/dvvm_pkg.sv | 19 +
 rtl/dot_product_ctrl_if.sv | 36 +++
 rtl/dot_acc.sv | 36 +++
 rtl/dot_product_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dvvm_pkg.sv
// Shared definitions for the dense vector-vector multiplier blocks:
// default widths, the multiply-unit latency and the sequencer state type.
package dvvm_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;
   localparam int ACC_W_DEF  = 24;

   // Cycles from a mac_en cycle to the mac_done cycle carrying its product.
   localparam int MAC_LAT = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } dvvm_state_e;

endpackage

// File: rtl/dot_product_ctrl_if.sv
// Host, operand-buffer and multiply-unit signals of the dot-product sequencer.
// The slave modport is the sequencer; master is the surrounding environment.
interface dot_product_ctrl_if
   import dvvm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) ();

   logic                start;
   logic [ADDR_W:0]     vec_len;
   logic                busy;
   logic [ADDR_W-1:0]   buf_addr;
   logic [DATA_W-1:0]   buf_a_q;
   logic [DATA_W-1:0]   buf_b_q;
   logic                mac_en;
   logic [DATA_W-1:0]   mac_a;
   logic [DATA_W-1:0]   mac_b;
   logic [2*DATA_W-1:0] mac_result;
   logic                mac_done;
   logic [ACC_W-1:0]    dot_result;
   logic                dot_valid;
   logic                dot_ready;

   modport slave (
      input  start, vec_len, buf_a_q, buf_b_q, mac_result, mac_done, dot_ready,
      output busy, buf_addr, mac_en, mac_a, mac_b, dot_result, dot_valid
   );

   modport master (
      output start, vec_len, buf_a_q, buf_b_q, mac_result, mac_done, dot_ready,
      input  busy, buf_addr, mac_en, mac_a, mac_b, dot_result, dot_valid
   );

endinterface

// File: rtl/dot_acc.sv
// Dot-product accumulator: clears when a run starts, adds zero-extended products
// on add_en and holds its value otherwise.
module dot_acc
   import dvvm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                add_en,
   input  logic [2*DATA_W-1:0] addend,
   output logic [ACC_W-1:0]    acc
);

   logic [ACC_W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (add_en)
         acc_d = acc_q + ACC_W'(addend);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: issues buffer addresses, streams operand pairs to the multiply
// unit and accumulates its products. Define DOT_CYCLE_CNT_EN to add the cyc_cnt output.
module dot_product_ctrl
   import dvvm_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   dot_product_ctrl_if.slave bus
`ifdef DOT_CYCLE_CNT_EN
   ,
   output logic [31:0]       cyc_cnt
`endif
);

   localparam int CNT_W = ADDR_W + 1;

   if (ACC_W < 2*DATA_W + ADDR_W) begin : g_acc_w_chk
      $error("dot_product_ctrl: ACC_W must be >= 2*DATA_W+ADDR_W");
   end

   dvvm_state_e         state_q, state_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;
   logic                rd_vld_q, rd_vld_d;
   logic                mac_en_q, mac_en_d;
   logic [DATA_W-1:0]   mac_a_q, mac_a_d;
   logic [DATA_W-1:0]   mac_b_q, mac_b_d;
   logic [MAC_LAT-1:0]  inflight_q, inflight_d;
   logic                busy_q, busy_d;
   logic                dot_valid_q, dot_valid_d;
   logic                start_acc;
   logic                add_en;

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      issue_cnt_d  = issue_cnt_q;
      retire_cnt_d = retire_cnt_q;
      start_acc    = 1'b0;

      // A product counts only while a run is active and a pair was sent MAC_LAT cycles ago.
      add_en = bus.mac_done && inflight_q[MAC_LAT-1] &&
               ((state_q == ISSUE) || (state_q == DRAIN));
      if (add_en)
         retire_cnt_d = retire_cnt_q + CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               start_acc    = 1'b1;
               len_d        = bus.vec_len;
               issue_cnt_d  = '0;
               retire_cnt_d = '0;
               state_d      = (bus.vec_len == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            if (issue_cnt_d == len_q)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (retire_cnt_q == len_q)
               state_d = DONE;
         end
         DONE: begin
            if (dot_valid_q && bus.dot_ready)
               state_d = IDLE;
         end
      endcase

      // Buffer data arrives one cycle after its address; register it as the operand pair.
      rd_vld_d    = (state_q == ISSUE);
      mac_en_d    = rd_vld_q;
      mac_a_d     = rd_vld_q ? bus.buf_a_q : mac_a_q;
      mac_b_d     = rd_vld_q ? bus.buf_b_q : mac_b_q;
      inflight_d  = {inflight_q[MAC_LAT-2:0], mac_en_q};
      busy_d      = (state_d != IDLE);
      dot_valid_d = (state_d == DONE);
   end

   // NOTE: sequential state uses <= only, and every flop is async reset so rst aborts a run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         len_q        <= '0;
         issue_cnt_q  <= '0;
         retire_cnt_q <= '0;
         rd_vld_q     <= 1'b0;
         mac_en_q     <= 1'b0;
         mac_a_q      <= '0;
         mac_b_q      <= '0;
         inflight_q   <= '0;
         busy_q       <= 1'b0;
         dot_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         issue_cnt_q  <= issue_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         rd_vld_q     <= rd_vld_d;
         mac_en_q     <= mac_en_d;
         mac_a_q      <= mac_a_d;
         mac_b_q      <= mac_b_d;
         inflight_q   <= inflight_d;
         busy_q       <= busy_d;
         dot_valid_q  <= dot_valid_d;
      end
   end

   dot_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_acc),
      .add_en (add_en),
      .addend (bus.mac_result),
      .acc    (bus.dot_result)
   );

   // The low bits of the issue counter wrap to 0 only after address 2**ADDR_W-1 is issued.
   assign bus.buf_addr  = issue_cnt_q[ADDR_W-1:0];
   assign bus.mac_en    = mac_en_q;
   assign bus.mac_a     = mac_a_q;
   assign bus.mac_b     = mac_b_q;
   assign bus.busy      = busy_q;
   assign bus.dot_valid = dot_valid_q;

`ifdef DOT_CYCLE_CNT_EN
   logic [31:0] cyc_cnt_q, cyc_cnt_d;

   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      if (start_acc)
         cyc_cnt_d = '0;
      else if (busy_q)
         cyc_cnt_d = cyc_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cyc_cnt_q <= '0;
      else
         cyc_cnt_q <= cyc_cnt_d;
   end

   assign cyc_cnt = cyc_cnt_q;
`endif

endmodule
